imem_loader: RTL and testbench

//   Boot-time program loader sitting directly upstream of the beta core's instruction memory.

---
 rtl/loader_pkg.sv | 17 +
 rtl/byte_assembler.sv | 39 +++
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | loader_pkg : shared constants and state encoding for imem_loader    |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
package loader_pkg;
   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_W          = 16;

   localparam logic [2:0] S_LEN_LO = 3'd0;
   localparam logic [2:0] S_LEN_HI = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_CSUM   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;
endpackage
`default_nettype wire

// File: rtl/byte_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | byte_assembler : packs LSB-first bytes into little-endian words     |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module byte_assembler
   import loader_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic [7:0]                  byte_in,
   input  logic                        byte_valid,
   output logic                        word_valid,
   output logic [8*BYTES_PER_WORD-1:0] word
);
   logic [1:0]  r_idx;
   logic [23:0] r_low;

   // Bytes shift in from the top so the first byte ends up in bits [7:0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
         r_low <= '0;
      end else if (clear) begin
         r_idx <= '0;
         r_low <= '0;
      end else if (byte_valid) begin
         r_idx <= r_idx + 2'd1;
         if (r_idx != 2'd3) begin
            r_low <= {byte_in, r_low[23:8]};
         end
      end
   end

   assign word_valid = byte_valid && !clear && (r_idx == 2'd3);
   assign word       = {byte_in, r_low};
endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_loader : boot loader filling instruction memory from a stream  |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
module imem_loader
   import loader_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              restart,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [WORD_W-1:0] im_wdata,
   output logic              core_run,
   output logic              load_done,
   output logic              load_err,
   output logic [LEN_W-1:0]  words_loaded
);
   localparam logic [LEN_W-1:0] c_depth = LEN_W'(DEPTH);

   logic [2:0]        r_state;
   logic [7:0]        r_len_lo;
   logic [LEN_W-1:0]  r_len;
   logic [7:0]        r_csum;

   logic              w_accept;
   logic              w_restart;
   logic              w_word_valid;
   logic [WORD_W-1:0] w_word;
   logic [LEN_W-1:0]  w_len;
   logic              w_last_word;

   assign in_ready    = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CSUM);
   assign w_accept    = in_valid && in_ready;
   assign w_restart   = restart && ((r_state == S_DONE) || (r_state == S_ERROR));
   assign w_len       = {in_data, r_len_lo};
   assign w_last_word = w_word_valid && ((words_loaded + LEN_W'(1)) == r_len);

   byte_assembler u_asm (
      .clk        (clk),
      .rst_n      (RESET),
      .clear      (w_restart),
      .byte_in    (in_data),
      .byte_valid (w_accept && (r_state == S_DATA)),
      .word_valid (w_word_valid),
      .word       (w_word)
   );

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_state      <= S_LEN_LO;
         r_len_lo     <= '0;
         r_len        <= '0;
         r_csum       <= '0;
         im_we        <= 1'b0;
         im_addr      <= '0;
         im_wdata     <= '0;
         core_run     <= 1'b0;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         words_loaded <= '0;
      end else begin
         im_we <= 1'b0;
         // words_loaded never exceeds DEPTH-1 while a write is pending, so the slice is the address.
         if (w_word_valid) begin
            im_we        <= 1'b1;
            im_wdata     <= w_word;
            im_addr      <= words_loaded[ADDR_W-1:0];
            words_loaded <= words_loaded + LEN_W'(1);
         end
         if (w_accept && (r_state == S_DATA)) begin
            r_csum <= r_csum ^ in_data;
         end

         case (r_state)
            S_LEN_LO: begin
               if (w_accept) begin
                  r_len_lo <= in_data;
                  r_state  <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (w_accept) begin
                  r_len <= w_len;
                  if (w_len == '0) begin
                     r_state <= S_CSUM;
                  end else if (w_len > c_depth) begin
                     r_state  <= S_ERROR;
                     load_err <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_last_word) begin
                  r_state <= S_CSUM;
               end
            end
            S_CSUM: begin
               if (w_accept) begin
                  if (in_data == r_csum) begin
                     r_state   <= S_DONE;
                     load_done <= 1'b1;
                     core_run  <= 1'b1;
                  end else begin
                     r_state  <= S_ERROR;
                     load_err <= 1'b1;
                  end
               end
            end
            S_DONE, S_ERROR: begin
               if (w_restart) begin
                  r_state      <= S_LEN_LO;
                  core_run     <= 1'b0;
                  load_done    <= 1'b0;
                  load_err     <= 1'b0;
                  words_loaded <= '0;
                  r_csum       <= '0;
               end
            end
            default: r_state <= S_LEN_LO;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_imem_loader : self-checking bench for imem_loader                |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        RESET;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        restart;
   logic        im_we;
   logic [7:0]  im_addr;
   logic [31:0] im_wdata;
   logic        core_run;
   logic        load_done;
   logic        load_err;
   logic [15:0] words_loaded;

   always #5 clk = ~clk;

   imem_loader #(.WORD_W(32), .ADDR_W(8), .DEPTH(256)) dut (
      .clk          (clk),
      .RESET        (RESET),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .restart      (restart),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .core_run     (core_run),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   typedef struct {
      logic [15:0]      len;
      logic [3:0][31:0] w;
      logic [7:0]       csum;
      int               gap;
      logic             exp_done;
      logic             exp_err;
      logic [15:0]      exp_wl;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] pay [256];
   logic [39:0] wq [$];
   logic [39:0] ew [$];

   // Every write pulse seen by the memory port, in order.
   always @(negedge clk) begin
      if (im_we) wq.push_back({im_addr, im_wdata});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      int waited;
      ok = 1'b0;
      waited = 0;
      for (int i = 0; i < gap; i++) @(negedge clk);
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      while (!ok && waited < 100) begin
         ok = in_ready;
         @(posedge clk);
         waited++;
         if (!ok) @(negedge clk);
      end
      #1 in_valid = 1'b0;
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL handshake: got no in_ready expected acceptance of byte 0x%0h", b);
      end
   endtask

   function automatic int gap_of(input int g);
      return (g < 0) ? int'($urandom_range(0, 2)) : g;
   endfunction

   // Sends one frame using pay[] as payload; stops after the length if it is oversized.
   task automatic run_frame(input logic [15:0] len, input logic [7:0] csum, input int g);
      send_byte(len[7:0], gap_of(g));
      send_byte(len[15:8], gap_of(g));
      if (len <= 16'd256) begin
         for (int i = 0; i < int'(len); i++)
            for (int k = 0; k < 4; k++)
               send_byte(pay[i][8*k +: 8], gap_of(g));
         send_byte(csum, gap_of(g));
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input logic done, input logic err, input logic [15:0] wl);
      chk({tag, ".wr_count"}, wq.size(), ew.size());
      for (int i = 0; i < ew.size() && i < wq.size(); i++) begin
         chk({tag, ".wr_addr"}, 32'(wq[i][39:32]), 32'(ew[i][39:32]));
         chk({tag, ".wr_data"}, wq[i][31:0], ew[i][31:0]);
      end
      chk({tag, ".load_done"}, 32'(load_done), 32'(done));
      chk({tag, ".load_err"}, 32'(load_err), 32'(err));
      chk({tag, ".core_run"}, 32'(core_run), 32'(done));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(0));
      chk({tag, ".words_loaded"}, 32'(words_loaded), 32'(wl));
   endtask

   task automatic do_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("restart.load_done", 32'(load_done), 32'(0));
      chk("restart.load_err", 32'(load_err), 32'(0));
      chk("restart.core_run", 32'(core_run), 32'(0));
      chk("restart.words_loaded", 32'(words_loaded), 32'(0));
      chk("restart.in_ready", 32'(in_ready), 32'(1));
      wq.delete();
   endtask

   vec_t tbl [6];

   initial begin
      // The twelve payload bytes 11..88,01,00,00,00 XOR to 0x89.
      tbl[0] = '{16'd3, {32'h0, 32'h00000001, 32'h88776655, 32'h44332211}, 8'h89, 0, 1'b1, 1'b0, 16'd3};
      tbl[1] = '{16'd3, {32'h0, 32'h00000001, 32'h88776655, 32'h44332211}, 8'h89, 1, 1'b1, 1'b0, 16'd3};
      tbl[2] = '{16'd3, {32'h0, 32'h00000001, 32'h88776655, 32'h44332211}, 8'hFF, 0, 1'b0, 1'b1, 16'd3};
      tbl[3] = '{16'h0101, {32'h0, 32'h0, 32'h0, 32'h0}, 8'h00, 0, 1'b0, 1'b1, 16'd0};
      tbl[4] = '{16'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 8'h00, 0, 1'b1, 1'b0, 16'd0};
      tbl[5] = '{16'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 8'h5A, 0, 1'b0, 1'b1, 16'd0};

      RESET = 1'b0; in_data = '0; in_valid = 1'b0; restart = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.im_we", 32'(im_we), 32'(0));
      chk("reset.im_addr", 32'(im_addr), 32'(0));
      chk("reset.im_wdata", im_wdata, 32'(0));
      chk("reset.core_run", 32'(core_run), 32'(0));
      chk("reset.load_done", 32'(load_done), 32'(0));
      chk("reset.load_err", 32'(load_err), 32'(0));
      chk("reset.words_loaded", 32'(words_loaded), 32'(0));
      chk("reset.in_ready", 32'(in_ready), 32'(1));
      RESET = 1'b1;

      // Write latency, then asynchronous reset while the first write is on the port.
      send_byte(8'h03, 0); send_byte(8'h00, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
      @(negedge clk);
      chk("lat.im_we", 32'(im_we), 32'(1));
      chk("lat.im_addr", 32'(im_addr), 32'(0));
      chk("lat.im_wdata", im_wdata, 32'h44332211);
      chk("lat.words_loaded", 32'(words_loaded), 32'(1));
      chk("lat.in_ready", 32'(in_ready), 32'(1));
      #2 RESET = 1'b0;
      #1;
      chk("midrst.im_we", 32'(im_we), 32'(0));
      chk("midrst.im_wdata", im_wdata, 32'(0));
      chk("midrst.words_loaded", 32'(words_loaded), 32'(0));
      chk("midrst.load_done", 32'(load_done), 32'(0));
      @(negedge clk);
      RESET = 1'b1;
      wq.delete();

      for (int i = 0; i < 4; i++) pay[i] = tbl[0].w[i];
      ew.delete();
      for (int i = 0; i < 3; i++) ew.push_back({8'(i), tbl[0].w[i]});
      run_frame(tbl[0].len, tbl[0].csum, 0);
      check_frame("reload", 1'b1, 1'b0, 16'd3);

      for (int v = 0; v < 6; v++) begin
         do_restart();
         ew.delete();
         for (int i = 0; i < 4; i++) pay[i] = tbl[v].w[i];
         if (tbl[v].len <= 16'd256)
            for (int i = 0; i < int'(tbl[v].len); i++) ew.push_back({8'(i), tbl[v].w[i]});
         run_frame(tbl[v].len, tbl[v].csum, tbl[v].gap);
         check_frame($sformatf("vec%0d", v), tbl[v].exp_done, tbl[v].exp_err, tbl[v].exp_wl);
      end

      // Random frames against a reference model built from the framing rules.
      for (int r = 0; r < 25; r++) begin
         logic [15:0] len;
         logic [7:0]  x;
         logic [7:0]  cs;
         logic        ok_len;
         logic        done;
         if (r == 0)                          len = 16'd256;
         else if ($urandom_range(0, 7) == 0)  len = 16'(257 + $urandom_range(0, 2000));
         else                                 len = 16'($urandom_range(0, 6));
         ok_len = (len <= 16'd256);
         x = 8'h00;
         ew.delete();
         if (ok_len) begin
            for (int i = 0; i < int'(len); i++) begin
               pay[i] = $urandom;
               ew.push_back({8'(i), pay[i]});
               x = x ^ pay[i][7:0] ^ pay[i][15:8] ^ pay[i][23:16] ^ pay[i][31:24];
            end
         end
         cs   = ($urandom_range(0, 3) == 0) ? 8'(x ^ 8'(1 + $urandom_range(0, 254))) : x;
         done = ok_len && (cs == x);
         do_restart();
         run_frame(len, cs, -1);
         check_frame($sformatf("rnd%0d", r), done, !done, ok_len ? len : 16'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
